// File: rtl/dma_rx_mux_if.sv
// Stream bundle between the IFFT source channels, the RX funnel and the DMA S2MM sink.
// master: the funnel side; slave: the environment driving sources and sink ready.
interface dma_rx_mux_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 64
);
  logic [NUM_CH-1:0]        s_axis_tvld;
  logic [NUM_CH*DATA_W-1:0] s_axis_tdat;
  logic [NUM_CH-1:0]        s_axis_trdy;
  logic                     m_axi_dma_trdy;
  logic                     m_axi_dma_tvld;
  logic [DATA_W-1:0]        m_axi_dma_tdat;
  logic                     m_axi_dma_tlast;

  modport master (
    input  s_axis_tvld, s_axis_tdat, m_axi_dma_trdy,
    output s_axis_trdy, m_axi_dma_tvld, m_axi_dma_tdat, m_axi_dma_tlast
  );

  modport slave (
    output s_axis_tvld, s_axis_tdat, m_axi_dma_trdy,
    input  s_axis_trdy, m_axi_dma_tvld, m_axi_dma_tdat, m_axi_dma_tlast
  );
endinterface

// File: rtl/dma_rx_mux.sv
// N-channel DMA RX funnel: one frame per channel, ch0..chN-1, onto a single stream with TLAST per frame.
// Optional pass counter enabled by macro DMA_RX_MUX_PASS_CNT_EN; otherwise pass_cnt is tied to zero.
module dma_rx_mux #(
  parameter int NUM_CH         = 2,
  parameter int DATA_W         = 64,
  parameter int FRAME_LEN_LOG2 = 13
) (
  input  logic              clk_dma,
  input  logic              srst,
  input  logic              start_rx_dma,
  input  logic [NUM_CH-1:0] ram_rdy,
  dma_rx_mux_if.master      bus,
  output logic              rx_busy,
  output logic              rx_done,
  output logic [15:0]       pass_cnt
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {WAIT_RDY, IDLE, XFER, GAP} state_t;

  state_t                    state, state_nxt;
  logic [CH_W-1:0]           ch;
  logic [FRAME_LEN_LOG2-1:0] beat;
  logic                      xfer;
  logic                      accept;
  logic                      final_beat;
  logic                      sel_vld;
  logic [DATA_W-1:0]         sel_dat;

  always_ff @(posedge clk_dma) begin
    if (srst) begin
      state   <= WAIT_RDY;
      ch      <= '0;
      beat    <= '0;
      rx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      rx_done <= final_beat & (ch == LAST_CH);
      if (accept)
        beat <= beat + 1'b1;
      if (state == GAP)
        ch <= ch + 1'b1;
      else if (final_beat && ch == LAST_CH)
        ch <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_RDY: if (&ram_rdy)     state_nxt = IDLE;
      IDLE:     if (start_rx_dma) state_nxt = XFER;
      XFER:     if (final_beat)   state_nxt = (ch == LAST_CH) ? WAIT_RDY : GAP;
      GAP:                        state_nxt = XFER;
    endcase
  end

  // Source selection is a compare-per-channel mux so non-power-of-two NUM_CH never indexes out of range.
  always_comb begin
    sel_vld = 1'b0;
    sel_dat = '0;
    xfer    = (state == XFER);
    bus.s_axis_trdy = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch == CH_W'(k)) begin
        sel_vld = bus.s_axis_tvld[k];
        sel_dat = bus.s_axis_tdat[k*DATA_W +: DATA_W];
      end
      bus.s_axis_trdy[k] = bus.m_axi_dma_trdy & xfer & (ch == CH_W'(k));
    end
    bus.m_axi_dma_tvld  = sel_vld & xfer;
    bus.m_axi_dma_tdat  = sel_dat;
    bus.m_axi_dma_tlast = xfer & (beat == '1);
    accept     = bus.m_axi_dma_tvld & bus.m_axi_dma_trdy;
    final_beat = accept & (beat == '1);
    rx_busy    = xfer | (state == GAP);
  end

`ifdef DMA_RX_MUX_PASS_CNT_EN
  logic [15:0] pass_q;

  always_ff @(posedge clk_dma) begin
    if (srst)
      pass_q <= '0;
    else if (rx_done)
      pass_q <= pass_q + 1'b1;
  end

  assign pass_cnt = pass_q;
`else
  assign pass_cnt = '0;
`endif

endmodule

// File: tb/tb_dma_rx_mux.sv
// Bench for dma_rx_mux with 2 channels and 8-beat frames; sources are modelled as per-channel queues
// and the sink output is compared against the concatenated expected frame stream.
module tb_dma_rx_mux;
  localparam int NUM_CH = 2;
  localparam int DATA_W = 64;
  localparam int FL2    = 3;
  localparam int FRAME  = 8;
  localparam int TOTAL  = NUM_CH * FRAME;

  logic              clk_dma = 1'b0;
  logic              srst;
  logic              start_rx_dma;
  logic [NUM_CH-1:0] ram_rdy;
  logic              rx_busy;
  logic              rx_done;
  logic [15:0]       pass_cnt;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_passes = 0;

  always #5 clk_dma = ~clk_dma;

  dma_rx_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  dma_rx_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_LEN_LOG2(FL2)) dut (
    .clk_dma      (clk_dma),
    .srst         (srst),
    .start_rx_dma (start_rx_dma),
    .ram_rdy      (ram_rdy),
    .bus          (bus),
    .rx_busy      (rx_busy),
    .rx_done      (rx_done),
    .pass_cnt     (pass_cnt)
  );

  function automatic logic [15:0] exp_pass_cnt();
`ifdef DMA_RX_MUX_PASS_CNT_EN
    return 16'(exp_passes);
`else
    return 16'd0;
`endif
  endfunction

  task automatic idle_cycle();
    @(negedge clk_dma);
    bus.s_axis_tvld    = '0;
    bus.m_axi_dma_trdy = 1'b1;
    #1;
  endtask

  // Waits for ch0 to be offered ready; optionally checks the two-cycle WAIT_RDY->IDLE->XFER latency.
  task automatic arm(input bit keep_start, input bit check_lat);
    bit seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk_dma);
      ram_rdy            = '1;
      start_rx_dma       = 1'b1;
      bus.s_axis_tvld    = '0;
      bus.m_axi_dma_trdy = 1'b1;
      #1;
      if (bus.s_axis_trdy[0] === 1'b1) begin
        seen = 1;
        if (check_lat) begin
          checks++;
          if (i != 2) begin
            errors++;
            $display("FAIL arm_latency: trdy0 rose after %0d clks, expected 2", i);
          end
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL arm_timeout: trdy0 never rose, got 0 expected 1");
    end
    if (!keep_start) start_rx_dma = 1'b0;
  endtask

  // trdy_mode: 0 always ready, 1 toggling 1010..., 2 random. abort_at >= 0 stops after that many beats.
  task automatic drive_pass(input int trdy_mode, input bit drop_vld, input int abort_at);
    logic [DATA_W-1:0] src0[$];
    logic [DATA_W-1:0] src1[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] d;
    bit p0, p1;
    int n = 0, cyc = 0, last_cyc = -10, done_cyc = -10, exp_ch;
    bit finished = 0;
    for (int i = 0; i < FRAME; i++) begin
      d = (trdy_mode == 0) ? DATA_W'(i) : {$urandom, $urandom};
      src0.push_back(d);
      exp_q.push_back(d);
    end
    for (int i = 0; i < FRAME; i++) begin
      d = (trdy_mode == 0) ? DATA_W'(16 + i) : {$urandom, $urandom};
      src1.push_back(d);
      exp_q.push_back(d);
    end
    while (!finished && cyc < 300) begin
      @(negedge clk_dma);
      case (trdy_mode)
        0:       bus.m_axi_dma_trdy = 1'b1;
        1:       bus.m_axi_dma_trdy = (cyc % 2 == 0);
        default: bus.m_axi_dma_trdy = 1'($urandom_range(0, 1));
      endcase
      bus.s_axis_tvld[0] = (src0.size() != 0) && !(drop_vld && cyc >= 6 && cyc <= 8);
      bus.s_axis_tvld[1] = (src1.size() != 0);
      bus.s_axis_tdat[0 +: DATA_W]      = (src0.size() != 0) ? src0[0] : '0;
      bus.s_axis_tdat[DATA_W +: DATA_W] = (src1.size() != 0) ? src1[0] : '0;
      #1;
      exp_ch = (n < FRAME) ? 0 : 1;
      checks++;
      if (rx_done !== (cyc == done_cyc + 1)) begin
        errors++;
        $display("FAIL rx_done: cyc %0d got %b expected %b", cyc, rx_done, (cyc == done_cyc + 1));
      end
      checks++;
      if (bus.s_axis_trdy[1 - exp_ch] !== 1'b0 || (n == TOTAL && bus.s_axis_trdy !== '0)) begin
        errors++;
        $display("FAIL inactive_trdy: beats %0d got trdy %b, expected only ch%0d", n, bus.s_axis_trdy, exp_ch);
      end
      p0 = bus.s_axis_trdy[0] && bus.s_axis_tvld[0];
      p1 = bus.s_axis_trdy[1] && bus.s_axis_tvld[1];
      if (bus.m_axi_dma_tvld === 1'b1 && bus.m_axi_dma_trdy === 1'b1) begin
        if (n >= TOTAL) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got beat %0d, expected %0d beats", n, TOTAL);
        end else begin
          checks++;
          if (bus.m_axi_dma_tdat !== exp_q[n]) begin
            errors++;
            $display("FAIL tdat: beat %0d got %h expected %h", n, bus.m_axi_dma_tdat, exp_q[n]);
          end
          checks++;
          if (bus.m_axi_dma_tlast !== (n % FRAME == FRAME - 1)) begin
            errors++;
            $display("FAIL tlast: beat %0d got %b expected %b", n, bus.m_axi_dma_tlast, (n % FRAME == FRAME - 1));
          end
          checks++;
          if (bus.s_axis_trdy[exp_ch] !== 1'b1) begin
            errors++;
            $display("FAIL src_trdy: beat %0d ch%0d got 0 expected 1", n, exp_ch);
          end
          if (trdy_mode == 0 && n > 0) begin
            checks++;
            if (cyc != last_cyc + ((n == FRAME) ? 2 : 1)) begin
              errors++;
              $display("FAIL spacing: beat %0d got %0d clks expected %0d", n, cyc - last_cyc, (n == FRAME) ? 2 : 1);
            end
          end
          last_cyc = cyc;
          n++;
          if (n == TOTAL) done_cyc = cyc;
        end
      end
      if (p0) void'(src0.pop_front());
      if (p1) void'(src1.pop_front());
      if (abort_at >= 0 && n == abort_at) finished = 1;
      if (n == TOTAL && cyc == done_cyc + 1) finished = 1;
      cyc++;
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL pass_timeout: got %0d beats expected %0d", n, (abort_at >= 0) ? abort_at : TOTAL);
    end else if (abort_at < 0) begin
      exp_passes++;
    end
  endtask

  task automatic check_pass_cnt(input string tag);
    idle_cycle();
    checks++;
    if (pass_cnt !== exp_pass_cnt()) begin
      errors++;
      $display("FAIL pass_cnt_%s: got %h expected %h", tag, pass_cnt, exp_pass_cnt());
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    ram_rdy = 2'b01;
    start_rx_dma = 1'b1;
    bus.s_axis_tvld = '0;
    bus.s_axis_tdat = '0;
    bus.m_axi_dma_trdy = 1'b1;
    exp_passes = 0;
    repeat (4) begin
      @(negedge clk_dma);
      #1;
      checks++;
      if ({bus.s_axis_trdy, bus.m_axi_dma_tvld, bus.m_axi_dma_tlast, rx_busy, rx_done, pass_cnt} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got trdy=%b tvld=%b tlast=%b busy=%b done=%b cnt=%h expected all 0",
                 bus.s_axis_trdy, bus.m_axi_dma_tvld, bus.m_axi_dma_tlast, rx_busy, rx_done, pass_cnt);
      end
    end
    @(negedge clk_dma);
    srst = 1'b0;
    repeat (4) begin
      @(negedge clk_dma);
      #1;
      checks++;
      if (bus.s_axis_trdy !== '0 || rx_busy !== 1'b0) begin
        errors++;
        $display("FAIL not_armed: got trdy=%b busy=%b expected 0 0", bus.s_axis_trdy, rx_busy);
      end
    end
    @(negedge clk_dma);
    start_rx_dma = 1'b0;
    arm(0, 1);
    drive_pass(0, 0, -1);
    check_pass_cnt("reset_pass");
  endtask

  task automatic test_full_pass();
    arm(0, 0);
    drive_pass(0, 0, -1);
    check_pass_cnt("full");
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_pass: got %b expected 0", rx_busy);
    end
  endtask

  task automatic test_backpressure();
    arm(0, 0);
    drive_pass(1, 1, -1);
    check_pass_cnt("backpressure");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      arm(0, 0);
      drive_pass(2, 0, -1);
    end
    check_pass_cnt("random");
  endtask

  task automatic test_back_to_back();
    arm(1, 0);
    drive_pass(0, 0, -1);
    idle_cycle();
    checks++;
    if (bus.s_axis_trdy !== '0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_early: got trdy=%b busy=%b expected 0 0", bus.s_axis_trdy, rx_busy);
    end
    idle_cycle();
    checks++;
    if (bus.s_axis_trdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart_latency: trdy0 got %b expected 1 two clks after rx_done", bus.s_axis_trdy[0]);
    end
    start_rx_dma = 1'b0;
    drive_pass(0, 0, -1);
    check_pass_cnt("back_to_back");
  endtask

  task automatic test_abort();
    arm(0, 0);
    drive_pass(0, 0, FRAME + 4);
    @(negedge clk_dma);
    bus.s_axis_tvld    = '0;
    bus.m_axi_dma_trdy = 1'b0;
    srst = 1'b1;
    @(negedge clk_dma);
    srst = 1'b0;
    bus.m_axi_dma_trdy = 1'b1;
    #1;
    checks++;
    if (bus.s_axis_trdy !== '0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got trdy=%b busy=%b expected 0 0", bus.s_axis_trdy, rx_busy);
    end
    repeat (4) begin
      idle_cycle();
      checks++;
      if (rx_done !== 1'b0) begin
        errors++;
        $display("FAIL abort_done: got %b expected 0", rx_done);
      end
    end
`ifdef DMA_RX_MUX_PASS_CNT_EN
    exp_passes = 0;
`endif
    check_pass_cnt("abort");
    arm(0, 0);
    drive_pass(0, 0, -1);
    check_pass_cnt("after_abort");
  endtask

  task automatic test_wrap();
`ifdef DMA_RX_MUX_PASS_CNT_EN
    @(negedge clk_dma);
    force dut.pass_q = 16'hFFFF;
    @(negedge clk_dma);
    release dut.pass_q;
    exp_passes = 32'hFFFF;
    check_pass_cnt("preset");
    arm(0, 0);
    drive_pass(0, 0, -1);
    check_pass_cnt("wrap");
`else
    arm(0, 0);
    drive_pass(2, 0, -1);
    check_pass_cnt("tied");
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_pass();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_abort();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
